// File: rtl/ps2_packet_framer_if.sv
// ps2_packet_framer_if: byte input and packet output bundle of the PS/2 packet framer.
//
// Handshake: in_valid is a one-cycle strobe qualifying in_byte. There is no
// ready, so the framer accepts every strobed byte. pkt_valid, sync_err and
// tmo_err are one-cycle strobes. pkt_data and pkt_cnt hold between strobes.
// dbg_state mirrors the framer FSM (0 = HUNT, 1 = COLLECT).
interface ps2_packet_framer_if #(
    parameter int PKT_BYTES = 3,
    parameter int CNT_W     = 16
);
    logic [7:0]             in_byte;
    logic                   in_valid;
    logic [8*PKT_BYTES-1:0] pkt_data;
    logic                   pkt_valid;
    logic                   sync_err;
    logic                   tmo_err;
    logic [CNT_W-1:0]       pkt_cnt;
    logic                   busy;
    logic                   dbg_state;

    // Byte source and packet consumer side
    modport master (
        output in_byte, in_valid,
        input  pkt_data, pkt_valid, sync_err, tmo_err, pkt_cnt, busy, dbg_state
    );

    // Framer side
    modport slave (
        input  in_byte, in_valid,
        output pkt_data, pkt_valid, sync_err, tmo_err, pkt_cnt, busy, dbg_state
    );
endinterface

// File: rtl/ps2_packet_framer.sv
// ps2_packet_framer: groups validated PS/2 bytes into PKT_BYTES-byte movement packets.
// The framer hunts for a header byte with bit SYNC_BIT set. It then collects
// the remaining bytes into a shadow register and publishes the complete packet
// with a one-cycle pkt_valid strobe.
// Optional feature macro PS2_FRAMER_TIMEOUT_EN: when defined, a partial packet
// is dropped after TIMEOUT_CYCLES idle cycles and tmo_err strobes. When the
// macro is undefined, tmo_err is tied to 0.
module ps2_packet_framer #(
    parameter int PKT_BYTES      = 3,
    parameter int SYNC_BIT       = 3,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input logic                clk,
    input logic                rst_n,
    ps2_packet_framer_if.slave bus
);

    localparam int         DW       = 8 * PKT_BYTES;
    localparam logic [2:0] LAST_IDX = 3'(PKT_BYTES - 1);

    // Reject illegal parameter combinations at elaboration
    if (PKT_BYTES < 2 || PKT_BYTES > 8 || SYNC_BIT < 0 || SYNC_BIT > 7 ||
        TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("ps2_packet_framer: illegal parameter value");
    end

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_idx;
    logic [2:0]       w_next_idx;
    logic [DW-1:0]    r_shadow;
    logic [DW-1:0]    r_pkt_data;
    logic [DW-1:0]    w_assembled;
    logic             r_pkt_valid;
    logic             r_sync_err;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic             w_store;
    logic             w_complete;
    logic             w_sync_err;
    logic             w_tmo_hit;

    // Shadow contents with the incoming byte merged at the current index.
    // In HUNT the index is 0, so a header lands in slot 0.
    always_comb begin
        w_assembled = r_shadow;
        w_assembled[{r_idx, 3'b000} +: 8] = bus.in_byte;
    end

`ifdef PS2_FRAMER_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_tmo_err;

    assign w_tmo_hit = (r_state == ST_COLLECT) && (r_tmo_cnt == TMO_LAST);

    // Idle-cycle counter: held at 0 in HUNT, cleared by every accepted byte and on expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state != ST_COLLECT || bus.in_valid || w_tmo_hit) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Timeout strobe; a byte arriving in the expiry cycle takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_err <= 1'b0;
        end else begin
            r_tmo_err <= w_tmo_hit && !bus.in_valid;
        end
    end

    assign bus.tmo_err = r_tmo_err;
`else
    assign w_tmo_hit   = 1'b0;
    assign bus.tmo_err = 1'b0;
`endif

    // Next-state logic: hunt for the sync bit, collect bytes, finish or time out
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_store      = 1'b0;
        w_complete   = 1'b0;
        w_sync_err   = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (bus.in_valid) begin
                    if (bus.in_byte[SYNC_BIT]) begin
                        w_store      = 1'b1;
                        w_next_idx   = 3'd1;
                        w_next_state = ST_COLLECT;
                    end else begin
                        w_sync_err = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (bus.in_valid) begin
                    w_store = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_complete   = 1'b1;
                        w_next_idx   = 3'd0;
                        w_next_state = ST_HUNT;
                    end else begin
                        w_next_idx = r_idx + 3'd1;
                    end
                end else if (w_tmo_hit) begin
                    w_next_idx   = 3'd0;
                    w_next_state = ST_HUNT;
                end
            end
            default: begin
                w_next_idx   = 3'd0;
                w_next_state = ST_HUNT;
            end
        endcase
    end

    // FSM state and byte index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_HUNT;
            r_idx   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end

    // Partial-packet shadow; stale slots are overwritten before the next publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (w_store) begin
            r_shadow <= w_assembled;
        end
    end

    // Published packet and counter, updated only when a packet completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_data <= '0;
            r_pkt_cnt  <= '0;
        end else if (w_complete) begin
            r_pkt_data <= w_assembled;
            r_pkt_cnt  <= r_pkt_cnt + 1'b1;
        end
    end

    // One-cycle packet and sync-error strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_pkt_valid <= w_complete;
            r_sync_err  <= w_sync_err;
        end
    end

    assign bus.pkt_data  = r_pkt_data;
    assign bus.pkt_valid = r_pkt_valid;
    assign bus.sync_err  = r_sync_err;
    assign bus.pkt_cnt   = r_pkt_cnt;
    assign bus.busy      = (r_state == ST_COLLECT);
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_ps2_packet_framer.sv
// tb_ps2_packet_framer: drives a 3-byte and a 4-byte framer with one shared byte stream.
// A packet-level reference model pushes expected strobes into per-DUT queues.
// A negedge monitor pops those queues and compares them with each strobe.
// The timeout scenarios run only when PS2_FRAMER_TIMEOUT_EN is defined.
module tb_ps2_packet_framer;

    localparam int TB_CW = 2;
    localparam int TMO   = 10;
    localparam int EW    = 3 + TB_CW + 64;
    localparam bit TMO_EN =
`ifdef PS2_FRAMER_TIMEOUT_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ps2_packet_framer_if #(.PKT_BYTES(3), .CNT_W(TB_CW)) bus0 ();
    ps2_packet_framer_if #(.PKT_BYTES(4), .CNT_W(TB_CW)) bus1 ();

    ps2_packet_framer #(
        .PKT_BYTES(3), .SYNC_BIT(3), .CNT_W(TB_CW), .TIMEOUT_CYCLES(TMO)
    ) u_dut0 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus0)
    );

    ps2_packet_framer #(
        .PKT_BYTES(4), .SYNC_BIT(3), .CNT_W(TB_CW), .TIMEOUT_CYCLES(TMO)
    ) u_dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state, one slot per DUT: bytes of the partial packet,
    // idle cycles since the last byte, completed-packet count and last packet.
    int          nb   [2];
    logic [7:0]  pb   [2][8];
    int          plen [2];
    int          idle [2];
    int          cnt  [2];
    logic [63:0] last [2];

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];

    // Expected strobe entry: {tmo_err, sync_err, pkt_valid, pkt_cnt, pkt_data}
    function automatic logic [EW-1:0] mk(input logic [2:0] k, input int c, input logic [63:0] d);
        return {k, TB_CW'(c), d};
    endfunction

    task automatic push_exp(input int d, input logic [EW-1:0] e);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            plen[d] = 0;
            idle[d] = 0;
            cnt[d]  = 0;
            last[d] = 64'd0;
        end
    endtask

    task automatic model_byte(input int d, input logic [7:0] b);
        logic [63:0] data;
        idle[d] = 0;
        if (plen[d] == 0) begin
            if (b[3]) begin
                pb[d][0] = b;
                plen[d]  = 1;
            end else begin
                push_exp(d, mk(3'b010, cnt[d], last[d]));
            end
        end else begin
            pb[d][plen[d]] = b;
            plen[d]++;
            if (plen[d] == nb[d]) begin
                data = 64'd0;
                for (int k = 0; k < nb[d]; k++) data = data | (64'(pb[d][k]) << (8 * k));
                last[d] = data;
                cnt[d]  = (cnt[d] + 1) % (1 << TB_CW);
                plen[d] = 0;
                push_exp(d, mk(3'b001, cnt[d], last[d]));
            end
        end
    endtask

    task automatic model_idle(input int d);
        if (TMO_EN && plen[d] > 0) begin
            idle[d]++;
            if (idle[d] == TMO) begin
                plen[d] = 0;
                idle[d] = 0;
                push_exp(d, mk(3'b100, cnt[d], last[d]));
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // One clock cycle of stimulus; busy is compared against the model before it advances
    task automatic cycle(input bit v, input logic [7:0] b);
        @(posedge clk);
        #1;
        if (rst_n) begin
            chk("busy0", 64'(bus0.busy), 64'(plen[0] > 0));
            chk("busy1", 64'(bus1.busy), 64'(plen[1] > 0));
        end
        bus0.in_valid = v;
        bus1.in_valid = v;
        bus0.in_byte  = v ? b : 8'($urandom);
        bus1.in_byte  = bus0.in_byte;
        for (int d = 0; d < 2; d++) begin
            if (v) model_byte(d, b);
            else   model_idle(d);
        end
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) cycle(1'b1, bytes[i]);
    endtask

    task automatic check_zero();
        chk("rst_data0",  64'(bus0.pkt_data),  64'd0);
        chk("rst_valid0", 64'(bus0.pkt_valid), 64'd0);
        chk("rst_sync0",  64'(bus0.sync_err),  64'd0);
        chk("rst_tmo0",   64'(bus0.tmo_err),   64'd0);
        chk("rst_cnt0",   64'(bus0.pkt_cnt),   64'd0);
        chk("rst_busy0",  64'(bus0.busy),      64'd0);
        chk("rst_data1",  64'(bus1.pkt_data),  64'd0);
        chk("rst_cnt1",   64'(bus1.pkt_cnt),   64'd0);
        chk("rst_busy1",  64'(bus1.busy),      64'd0);
    endtask

    // Let in-flight strobes reach the monitor, then reset asynchronously mid-cycle
    task automatic do_reset();
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        @(negedge clk);
        #1;
        chk("pre_rst_q0", 64'(exp_q0.size()), 64'd0);
        chk("pre_rst_q1", 64'(exp_q1.size()), 64'd0);
        rst_n = 1'b0;
        #1;
        check_zero();
        model_reset();
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every strobe must match the oldest expected entry of its DUT
    always @(negedge clk) begin : monitor
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        if (rst_n) begin
            if (bus0.pkt_valid || bus0.sync_err || bus0.tmo_err) begin
                act = {bus0.tmo_err, bus0.sync_err, bus0.pkt_valid, bus0.pkt_cnt, 64'(bus0.pkt_data)};
                checks++;
                if (exp_q0.size() == 0) begin
                    errors++;
                    $display("FAIL strobe0 act=%h exp=none", act);
                end else begin
                    e = exp_q0.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL strobe0 act=%h exp=%h", act, e);
                    end
                end
            end
            if (bus1.pkt_valid || bus1.sync_err || bus1.tmo_err) begin
                act = {bus1.tmo_err, bus1.sync_err, bus1.pkt_valid, bus1.pkt_cnt, 64'(bus1.pkt_data)};
                checks++;
                if (exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL strobe1 act=%h exp=none", act);
                end else begin
                    e = exp_q1.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL strobe1 act=%h exp=%h", act, e);
                    end
                end
            end
        end
    end

    // Main stimulus sequence
    initial begin
        int run;
        checks = 0;
        errors = 0;
        nb[0]  = 3;
        nb[1]  = 4;
        model_reset();
        rst_n         = 1'b0;
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        bus0.in_byte  = 8'h00;
        bus1.in_byte  = 8'h00;
        #2;
        check_zero();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic 3-byte packet
        send_bytes('{8'h08, 8'h12, 8'hF0});
        cycle(1'b0, 8'h00);
        chk("t1_valid0", 64'(bus0.pkt_valid), 64'd1);
        chk("t1_data0",  64'(bus0.pkt_data),  64'h0000_0000_00F0_1208);
        chk("t1_cnt0",   64'(bus0.pkt_cnt),   64'd1);

        // Hunting past bytes without the sync bit
        send_bytes('{8'h00, 8'h12, 8'h08, 8'h05, 8'hFB});
        cycle(1'b0, 8'h00);
        chk("t2_data0", 64'(bus0.pkt_data), 64'h0000_0000_00FB_0508);
        chk("t2_cnt0",  64'(bus0.pkt_cnt),  64'd2);

        // 4-byte packet followed immediately by the next header
        do_reset();
        send_bytes('{8'h09, 8'h01, 8'h02, 8'hFF, 8'h18});
        chk("t3_valid1", 64'(bus1.pkt_valid), 64'd1);
        chk("t3_data1",  64'(bus1.pkt_data),  64'h0000_0000_FF02_0109);
        send_bytes('{8'h33, 8'h44, 8'h55});
        cycle(1'b0, 8'h00);
        chk("t3_next1", 64'(bus1.pkt_data), 64'h0000_0000_5544_3318);

        // Reset in the middle of a packet, then a clean packet
        do_reset();
        send_bytes('{8'h08, 8'h12});
        do_reset();
        send_bytes('{8'h08, 8'hAA, 8'hBB, 8'hCC});
        cycle(1'b0, 8'h00);
        chk("t5_data1", 64'(bus1.pkt_data), 64'h0000_0000_CCBB_AA08);

        if (TMO_EN) begin
            // Partial packet dropped after the idle limit
            do_reset();
            send_bytes('{8'h08, 8'h12});
            repeat (TMO) cycle(1'b0, 8'h00);
            cycle(1'b0, 8'h00);
            chk("t4_tmo0",  64'(bus0.tmo_err), 64'd1);
            chk("t4_busy0", 64'(bus0.busy),    64'd0);
            send_bytes('{8'h08, 8'h01, 8'h02});
            cycle(1'b0, 8'h00);
            chk("t4_data0", 64'(bus0.pkt_data), 64'h0000_0000_0002_0108);
            // A byte on the expiry cycle is accepted
            do_reset();
            cycle(1'b1, 8'h08);
            repeat (TMO - 1) cycle(1'b0, 8'h00);
            send_bytes('{8'h01, 8'h02});
            cycle(1'b0, 8'h00);
            chk("t4_exp_valid0", 64'(bus0.pkt_valid), 64'd1);
            chk("t4_exp_data0",  64'(bus0.pkt_data),  64'h0000_0000_0002_0108);
        end

        // Randomized traffic, with occasional long idle gaps
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                run = $urandom_range(5, 14);
                repeat (run) cycle(1'b0, 8'h00);
            end else begin
                cycle($urandom_range(0, 9) < 6, 8'($urandom_range(0, 255)));
            end
        end

        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        @(negedge clk);
        #1;
        chk("drain_q0", 64'(exp_q0.size()), 64'd0);
        chk("drain_q1", 64'(exp_q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
